// File: rtl/router_pkg.sv
// Shared types and field layout for the 1x3 router packet path.
// Header byte is {len, addr}; the helper keeps the layout in one place.
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } tx_state_t;

    function automatic logic [DATA_W-1:0] make_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        logic [DATA_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_ADDR_LSB +: ADDR_W] = addr;
        hdr[HDR_LEN_LSB  +: LEN_W]  = len;
        return hdr;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Byte-wide XOR accumulator with clear, load and xor-enable.
// Clear wins over load, load wins over xor; shared by the tx and rx sides.
module router_parity_acc
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_xor_en,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_acc
);

    logic [DATA_W-1:0] r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_din;
        end else if (i_xor_en) begin
            r_acc <= r_acc ^ i_din;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/router_pkt_tx.sv
// Router-side packet transmitter: header, payload, parity, then an idle gap.
// Every wire byte holds on data_out until an edge with busy low consumes it.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  pay_len,
    input  logic              err_inject,
    input  logic [DATA_W-1:0] pay_data,
    output logic              pay_rd,
    input  logic              busy,
    output logic              pkt_vld,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_active,
    output logic              done,
    output logic              start_err
);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_inject;
    logic [3:0]        r_gap_cnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_pkt_vld;
    logic              r_done;
    logic              r_start_err;

    logic              w_start_legal;
    logic              w_accept;
    logic              w_reject;
    logic              w_pay_rd;
    logic              w_to_parity;
    logic              w_to_gap;
    logic              w_gap_end;
    logic [DATA_W-1:0] w_header;
    logic [DATA_W-1:0] w_parity;

    assign w_start_legal = (dest_addr != ADDR_ILLEGAL) && (pay_len != '0);
    assign w_header      = make_header(pay_len, dest_addr);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_pay_rd     = 1'b0;
        w_to_parity  = 1'b0;
        w_to_gap     = 1'b0;
        w_gap_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_start_legal) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_HEADER;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_HEADER, ST_PAYLOAD: begin
                if (!busy) begin
                    if (r_remaining != '0) begin
                        w_pay_rd     = 1'b1;
                        w_state_next = ST_PAYLOAD;
                    end else begin
                        w_to_parity  = 1'b1;
                        w_state_next = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (!busy) begin
                    w_to_gap     = 1'b1;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_gap_end    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Header seeds the accumulator so parity covers header plus payload.
    router_parity_acc u_parity (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_to_gap),
        .i_load   (w_accept),
        .i_xor_en (w_pay_rd),
        .i_din    (w_accept ? w_header : pay_data),
        .o_acc    (w_parity)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_inject    <= 1'b0;
            r_gap_cnt   <= 4'd0;
            r_data_out  <= '0;
            r_pkt_vld   <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_done      <= w_gap_end;
            r_start_err <= w_reject;
            if (w_accept) begin
                r_data_out  <= w_header;
                r_pkt_vld   <= 1'b1;
                r_remaining <= pay_len;
                r_inject    <= err_inject;
            end else if (w_pay_rd) begin
                r_data_out  <= pay_data;
                r_remaining <= r_remaining - LEN_W'(1);
            end else if (w_to_parity) begin
                r_data_out <= w_parity ^ {DATA_W{r_inject}};
                r_pkt_vld  <= 1'b0;
            end else if (w_to_gap) begin
                r_data_out <= '0;
                r_gap_cnt  <= 4'(GAP_CYCLES - 1);
            end else if (r_state == ST_GAP && r_gap_cnt != 4'd0) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
        end
    end

    assign pay_rd    = w_pay_rd;
    assign pkt_vld   = r_pkt_vld;
    assign data_out  = r_data_out;
    assign tx_active = (r_state != ST_IDLE);
    assign done      = r_done;
    assign start_err = r_start_err;

endmodule
